// File: rtl/mmc1_serial_writer.sv
// MMC1 serial register port bus initiator: turns a 5-bit register write command into
// D0 serial writes (or one D7 reset write) on a self-generated M2, and keeps mapper shadows.
module mmc1_serial_writer #(
    parameter int HALF_CLKS  = 6,
    parameter int GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_RESET,
    input  logic [1:0] CMD_REG,
    input  logic [4:0] CMD_DATA,
    output logic       DONE,
    output logic       CPU_M2,
    output logic       nCPU_ROMSEL,
    output logic       nCPU_RW,
    output logic       CPU_A14,
    output logic       CPU_A13,
    output logic       CPU_D0,
    output logic       CPU_D7,
    output logic [4:0] SH_CONTROL,
    output logic [4:0] SH_CHR0,
    output logic [4:0] SH_CHR1,
    output logic [4:0] SH_PRG
);

    localparam int              PERIOD        = 2 * HALF_CLKS;
    localparam int              PW            = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0]   PHASE_LAST    = PW'(PERIOD - 1);
    localparam logic [PW-1:0]   PHASE_HIGH    = PW'(HALF_CLKS);
    localparam int              GW            = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST      = GW'(GAP_CYCLES - 1);
    localparam logic [4:0]      CONTROL_RESET = 5'b01100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WRITE,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   phase;
    logic            armed;
    logic            cmd_is_reset;
    logic [1:0]      cmd_reg;
    logic [4:0]      cmd_data;
    logic [2:0]      bit_idx;
    logic [GW-1:0]   gap_cnt;
    logic [1:0]      addr_q;
    logic            done_q;

    logic            boundary;
    logic            last_write;
    logic            write_active;
    logic            accept;
    logic            start_write;
    logic            enter_gap;
    logic            gap_step;
    logic            next_write;
    logic            finish;

    assign boundary     = (phase == PHASE_LAST);
    assign last_write   = cmd_is_reset || (bit_idx == 3'd4);
    assign write_active = (state == S_WRITE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus-visible state only moves on boundaries; IDLE->ARM just latches the command.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        start_write = 1'b0;
        enter_gap   = 1'b0;
        gap_step    = 1'b0;
        next_write  = 1'b0;
        finish      = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && CMD_VALID) begin
                    accept     = 1'b1;
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (boundary) begin
                    start_write = 1'b1;
                    state_next  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (boundary) begin
                    enter_gap  = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (boundary) begin
                    if (gap_cnt == GAP_LAST) begin
                        if (last_write) begin
                            finish     = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            next_write = 1'b1;
                            state_next = S_WRITE;
                        end
                    end else begin
                        gap_step = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase        <= '0;
            armed        <= 1'b0;
            cmd_is_reset <= 1'b0;
            cmd_reg      <= 2'b00;
            cmd_data     <= 5'b00000;
            bit_idx      <= 3'd0;
            gap_cnt      <= '0;
            addr_q       <= 2'b00;
            done_q       <= 1'b0;
        end else begin
            phase  <= boundary ? '0 : phase + PW'(1);
            armed  <= 1'b1;
            done_q <= finish;
            if (accept) begin
                cmd_is_reset <= CMD_RESET;
                cmd_reg      <= CMD_REG;
                cmd_data     <= CMD_DATA;
            end
            // Address is only loaded at a boundary so it never moves mid M2 cycle.
            if (start_write) begin
                addr_q  <= cmd_reg;
                bit_idx <= 3'd0;
            end
            if (enter_gap) begin
                gap_cnt <= '0;
            end
            if (gap_step) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
            if (next_write) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Shadows mirror what the mapper latches on its fifth write or a D7 reset write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SH_CONTROL <= CONTROL_RESET;
            SH_CHR0    <= 5'b00000;
            SH_CHR1    <= 5'b00000;
            SH_PRG     <= 5'b00000;
        end else if (finish) begin
            if (cmd_is_reset) begin
                SH_CONTROL <= SH_CONTROL | CONTROL_RESET;
            end else begin
                case (cmd_reg)
                    2'b00:   SH_CONTROL <= cmd_data;
                    2'b01:   SH_CHR0    <= cmd_data;
                    2'b10:   SH_CHR1    <= cmd_data;
                    default: SH_PRG     <= cmd_data;
                endcase
            end
        end
    end

    assign CPU_M2      = (phase >= PHASE_HIGH);
    assign nCPU_RW     = !write_active;
    assign nCPU_ROMSEL = !(write_active && CPU_M2);
    assign CPU_A14     = addr_q[1];
    assign CPU_A13     = addr_q[0];
    assign CPU_D0      = write_active && !cmd_is_reset && cmd_data[bit_idx];
    assign CPU_D7      = write_active && cmd_is_reset;
    assign DONE        = done_q;
    assign CMD_READY   = (state == S_IDLE) && armed;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Bench for mmc1_serial_writer: two instances (HALF_CLKS=6/GAP=1 and HALF_CLKS=1/GAP=3)
// checked per M2 cycle against a command-level transcript and shadow model.
module tb_mmc1_serial_writer;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_reset;
    logic [1:0]       cmd_reg;
    logic [4:0]       cmd_data;
    logic [1:0]       cmd_valid;
    logic [1:0]       ready, done, m2, romsel, rw, a14, a13, d0, d7;
    logic [1:0][4:0]  sh_ctl, sh_chr0, sh_chr1, sh_prg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmc1_serial_writer #(.HALF_CLKS(6), .GAP_CYCLES(1)) u_dut0 (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid[0]), .CMD_READY(ready[0]),
        .CMD_RESET(cmd_reset), .CMD_REG(cmd_reg), .CMD_DATA(cmd_data), .DONE(done[0]),
        .CPU_M2(m2[0]), .nCPU_ROMSEL(romsel[0]), .nCPU_RW(rw[0]),
        .CPU_A14(a14[0]), .CPU_A13(a13[0]), .CPU_D0(d0[0]), .CPU_D7(d7[0]),
        .SH_CONTROL(sh_ctl[0]), .SH_CHR0(sh_chr0[0]), .SH_CHR1(sh_chr1[0]), .SH_PRG(sh_prg[0])
    );

    mmc1_serial_writer #(.HALF_CLKS(1), .GAP_CYCLES(3)) u_dut1 (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid[1]), .CMD_READY(ready[1]),
        .CMD_RESET(cmd_reset), .CMD_REG(cmd_reg), .CMD_DATA(cmd_data), .DONE(done[1]),
        .CPU_M2(m2[1]), .nCPU_ROMSEL(romsel[1]), .nCPU_RW(rw[1]),
        .CPU_A14(a14[1]), .CPU_A13(a13[1]), .CPU_D0(d0[1]), .CPU_D7(d7[1]),
        .SH_CONTROL(sh_ctl[1]), .SH_CHR0(sh_chr0[1]), .SH_CHR1(sh_chr1[1]), .SH_PRG(sh_prg[1])
    );

    function automatic int halfOf(input int g);
        return (g == 0) ? 6 : 1;
    endfunction

    function automatic int gapOf(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // One observed M2 cycle: bus values plus whether it was well formed throughout.
    typedef struct {
        bit       wr;
        bit       d0;
        bit       d7;
        bit [1:0] addr;
        bit       ok;
    } cyc_t;

    cyc_t rec [2][256];
    int   bclk [2][256];
    int   bcount [2]   = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   done_at [2]  = '{0, 0};
    int   done_clk [2] = '{0, 0};
    int   cur_len [2]  = '{0, 0};
    int   cur_start [2] = '{0, 0};
    bit   prev_m2 [2]  = '{0, 0};
    cyc_t cur [2];
    int   clk_n = 0;

    // M2 falling at a sample point marks a boundary; each cycle is recorded when it closes.
    always @(negedge clk) begin
        clk_n++;
        for (int g = 0; g < 2; g++) begin
            if (prev_m2[g] && !m2[g]) begin
                cur[g].ok = cur[g].ok && (cur_len[g] == 2 * halfOf(g));
                rec[g][cur_start[g] & 255] = cur[g];
                bcount[g]++;
                cur_start[g] = bcount[g];
                bclk[g][bcount[g] & 255] = clk_n;
                cur_len[g] = 0;
                cur[g].wr   = !rw[g];
                cur[g].d0   = d0[g];
                cur[g].d7   = d7[g];
                cur[g].addr = {a14[g], a13[g]};
                cur[g].ok   = 1'b1;
            end
            if (cur[g].wr != !rw[g] || cur[g].d0 != d0[g] || cur[g].d7 != d7[g] ||
                cur[g].addr != {a14[g], a13[g]})
                cur[g].ok = 1'b0;
            if (m2[g] != (cur_len[g] >= halfOf(g)))
                cur[g].ok = 1'b0;
            if (romsel[g] != !(!rw[g] && m2[g]))
                cur[g].ok = 1'b0;
            cur_len[g]++;
            prev_m2[g] = m2[g];
            if (done[g]) begin
                done_cnt[g]++;
                done_at[g]  = bcount[g];
                done_clk[g] = clk_n;
            end
        end
    end

    logic [4:0] msh [2][4];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int g, input bit is_rst, input bit [1:0] r, input bit [4:0] d);
        cmd_reset    = is_rst;
        cmd_reg      = r;
        cmd_data     = d;
        cmd_valid[g] = 1'b1;
    endtask

    task automatic modelReset();
        for (int g = 0; g < 2; g++) begin
            msh[g][0] = 5'b01100;
            msh[g][1] = 5'b00000;
            msh[g][2] = 5'b00000;
            msh[g][3] = 5'b00000;
        end
    endtask

    task automatic checkResetState(input int g);
        checkOutput("rst_m2", int'(m2[g]), 0);
        checkOutput("rst_romsel", int'(romsel[g]), 1);
        checkOutput("rst_rw", int'(rw[g]), 1);
        checkOutput("rst_addr", int'({a14[g], a13[g]}), 0);
        checkOutput("rst_data", int'({d0[g], d7[g]}), 0);
        checkOutput("rst_ready", int'(ready[g]), 0);
        checkOutput("rst_done", int'(done[g]), 0);
        checkOutput("rst_sh_ctl", int'(sh_ctl[g]), 12);
        checkOutput("rst_sh_chr", int'({sh_chr0[g], sh_chr1[g], sh_prg[g]}), 0);
    endtask

    task automatic checkShadows(input int g, input bit [4:0] c, input bit [4:0] c0,
                                input bit [4:0] c1, input bit [4:0] p);
        checkOutput("sh_control", int'(sh_ctl[g]), int'(c));
        checkOutput("sh_chr0", int'(sh_chr0[g]), int'(c0));
        checkOutput("sh_chr1", int'(sh_chr1[g]), int'(c1));
        checkOutput("sh_prg", int'(sh_prg[g]), int'(p));
    endtask

    // Issues one command and checks every M2 cycle of it against the expected transcript.
    task automatic runCommand(input int g, input bit is_rst, input bit [1:0] r, input bit [4:0] d,
                              input bit b2b, input bit churn);
        int n_cyc, b0, dc0, guard, per, bitn;
        logic [5:0] got, want;
        cyc_t c;
        per = 1 + gapOf(g);
        if (!b2b) begin
            tick();
            checkOutput("done_low", int'(done[g]), 0);
            guard = 0;
            while (!ready[g] && guard < 200) begin
                tick();
                guard++;
            end
        end
        checkOutput("ready_before", int'(ready[g]), 1);
        applyStimulus(g, is_rst, r, d);
        tick();
        checkOutput("ready_drop", int'(ready[g]), 0);
        b0  = bcount[g];
        dc0 = done_cnt[g];
        if (!churn) cmd_valid[g] = 1'b0;
        n_cyc = (is_rst ? 1 : 5) * per;
        guard = 0;
        while (bcount[g] <= b0 + n_cyc && guard < 4 * halfOf(g) * (n_cyc + 2)) begin
            if (churn) begin
                cmd_data  = 5'($urandom);
                cmd_reg   = 2'($urandom);
                cmd_reset = 1'($urandom);
            end
            tick();
            guard++;
        end
        cmd_valid[g] = 1'b0;
        if (bcount[g] <= b0 + n_cyc) begin
            checkOutput("cmd_timeout", bcount[g] - b0, n_cyc + 1);
            return;
        end
        for (int i = 0; i < n_cyc; i++) begin
            c    = rec[g][(b0 + 1 + i) & 255];
            bitn = i / per;
            got  = {c.wr, c.d0, c.d7, c.addr, c.ok};
            want = {(i % per) == 0, (i % per) == 0 && !is_rst && d[bitn],
                    (i % per) == 0 && is_rst, r, 1'b1};
            checkOutput($sformatf("cycle%0d_dut%0d", i, g), int'(got), int'(want));
        end
        if (b2b)
            checkOutput("b2b_idle", int'(rec[g][b0 & 255].wr), 0);
        checkOutput("done_bound", done_at[g] - b0, n_cyc + 1);
        checkOutput("done_count", done_cnt[g] - dc0, 1);
        checkOutput("done_clks", done_clk[g] - bclk[g][(b0 + 1) & 255], n_cyc * 2 * halfOf(g));
        checkOutput("done_now", int'(done[g]), 1);
        checkOutput("ready_back", int'(ready[g]), 1);
        if (is_rst) msh[g][0] = msh[g][0] | 5'b01100;
        else        msh[g][r] = d;
    endtask

    typedef struct {
        bit       rst_cmd;
        bit [1:0] r;
        bit [4:0] d;
        bit       b2b;
        bit [4:0] e_ctl, e_chr0, e_chr1, e_prg;
    } vec_t;

    vec_t vt [10];

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b0, dc0, guard;
        bit is_rst, b2b;
        bit [1:0] r;
        bit [4:0] d;

        vt[0] = '{0, 2'b00, 5'b01111, 0, 5'b01111, 5'b00000, 5'b00000, 5'b00000};
        vt[1] = '{0, 2'b00, 5'b00001, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        vt[2] = '{1, 2'b11, 5'b00000, 0, 5'b01101, 5'b00000, 5'b00000, 5'b00000};
        vt[3] = '{0, 2'b11, 5'b10101, 0, 5'b01101, 5'b00000, 5'b00000, 5'b10101};
        vt[4] = '{0, 2'b01, 5'b00011, 1, 5'b01101, 5'b00011, 5'b00000, 5'b10101};
        vt[5] = '{0, 2'b10, 5'b11010, 0, 5'b01101, 5'b00011, 5'b11010, 5'b10101};
        vt[6] = '{1, 2'b01, 5'b00000, 0, 5'b01101, 5'b00011, 5'b11010, 5'b10101};
        vt[7] = '{0, 2'b00, 5'b10000, 0, 5'b10000, 5'b00011, 5'b11010, 5'b10101};
        vt[8] = '{1, 2'b10, 5'b00000, 1, 5'b11100, 5'b00011, 5'b11010, 5'b10101};
        vt[9] = '{0, 2'b10, 5'b00000, 0, 5'b11100, 5'b00011, 5'b00000, 5'b10101};

        rst       = 1'b1;
        cmd_valid = 2'b00;
        cmd_reset = 1'b0;
        cmd_reg   = 2'b00;
        cmd_data  = 5'b00000;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) checkResetState(g);
        rst = 1'b0;
        checkOutput("ready_first_clk", int'(ready), 0);
        tick();
        checkOutput("ready_after_rst", int'(ready), 3);
        modelReset();

        for (int i = 0; i < 10; i++) begin
            runCommand(0, vt[i].rst_cmd, vt[i].r, vt[i].d, vt[i].b2b, 1'b0);
            checkShadows(0, vt[i].e_ctl, vt[i].e_chr0, vt[i].e_chr1, vt[i].e_prg);
        end

        // CMD_VALID held with churning inputs while busy: nothing extra may be accepted.
        runCommand(0, 1'b0, 2'b10, 5'b10110, 1'b0, 1'b1);
        checkShadows(0, msh[0][0], msh[0][1], msh[0][2], msh[0][3]);
        dc0 = done_cnt[0];
        repeat (30) tick();
        checkOutput("churn_no_extra", int'(ready[0]), 1);
        checkOutput("churn_no_done", done_cnt[0] - dc0, 0);

        runCommand(1, 1'b0, 2'b11, 5'b01011, 1'b0, 1'b0);
        checkShadows(1, msh[1][0], msh[1][1], msh[1][2], msh[1][3]);
        runCommand(1, 1'b1, 2'b01, 5'b00000, 1'b0, 1'b0);
        checkShadows(1, msh[1][0], msh[1][1], msh[1][2], msh[1][3]);

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) begin
                is_rst = ($urandom_range(0, 3) == 0);
                r      = 2'($urandom_range(0, 3));
                d      = 5'($urandom);
                b2b    = (i > 0) && ($urandom_range(0, 2) == 0);
                if (!b2b) repeat ($urandom_range(0, 13)) tick();
                runCommand(g, is_rst, r, d, b2b, 1'b0);
                checkShadows(g, msh[g][0], msh[g][1], msh[g][2], msh[g][3]);
            end
        end

        // Reset landing in the third write cycle of a serial load.
        tick();
        applyStimulus(0, 1'b0, 2'b01, 5'b11111);
        tick();
        cmd_valid[0] = 1'b0;
        b0  = bcount[0];
        dc0 = done_cnt[0];
        guard = 0;
        while (bcount[0] < b0 + 5 && guard < 200) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        checkOutput("third_write_active", int'({rw[0], d0[0], a14[0], a13[0]}), 5'b0_1_0_1);
        rst = 1'b1;
        tick();
        for (int g = 0; g < 2; g++) checkResetState(g);
        repeat (2) tick();
        checkOutput("rst_no_done", done_cnt[0] - dc0, 0);
        rst = 1'b0;
        checkOutput("ready_low_on_release", int'(ready[0]), 0);
        tick();
        checkOutput("ready_after_release", int'(ready[0]), 1);
        modelReset();

        runCommand(0, 1'b0, 2'b00, 5'b00110, 1'b0, 1'b0);
        checkShadows(0, 5'b00110, 5'b00000, 5'b00000, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
